// File: rtl/disp_pkg.sv
// Shared constants and types for the display read-channel arbiter.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned REQ_DISP = 0;
  localparam int unsigned REQ_AUX  = 1;
  localparam int unsigned CNT_W    = 8;

  localparam logic [7:0]       ARLEN_16 = 8'd15;
  localparam logic [CNT_W-1:0] CNT_MAX  = 8'hFF;

endpackage

// File: rtl/disp_rr_pick.sv
// Two-way winner select: strict display priority or round-robin, one-hot result.
module disp_rr_pick
  import disp_pkg::*;
#(
  parameter bit PRIO = 1'b1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick_c
);

  // last holds the index of the previously granted requester
  always_comb begin
    pick_c = '0;
    if (req[REQ_DISP] && (PRIO || !req[REQ_AUX] || (last == 1'(REQ_AUX)))) begin
      pick_c[REQ_DISP] = 1'b1;
    end else if (req[REQ_AUX]) begin
      pick_c[REQ_AUX] = 1'b1;
    end
  end

endmodule

// File: rtl/disp_rd_arbiter.sv
// Shares one AXI read channel (AR + R) between display fetch (req0) and an auxiliary engine (req1).
module disp_rd_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned DISP_PRIORITY      = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]                    S0_ARLEN,
  input  logic                          S0_ARVALID,
  output logic                          S0_ARREADY,
  output logic                          S0_RVALID,
  output logic                          S0_RLAST,
  input  logic                          S0_RREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]                    S1_ARLEN,
  input  logic                          S1_ARVALID,
  output logic                          S1_ARREADY,
  output logic                          S1_RVALID,
  output logic                          S1_RLAST,
  input  logic                          S1_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] S_RDATA,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]                    M_ARLEN,
  output logic                          M_ARVALID,
  input  logic                          M_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_RDATA,
  input  logic                          M_RLAST,
  input  logic                          M_RVALID,
  output logic                          M_RREADY,
  output logic [NUM_REQ-1:0]            GNT,
  output logic                          LEN_ERR,
  input  logic                          ERR_CLR
);

  state_t             state;
  logic               last_gnt;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] pick_c;
  logic               in_idle_c;
  logic               in_data_c;
  logic               r_hs_c;
  logic               len_bad_c;

  disp_rr_pick #(
    .PRIO (DISP_PRIORITY != 0)
  ) u_pick (
    .req    ({S1_ARVALID, S0_ARVALID}),
    .last   (last_gnt),
    .pick_c (pick_c)
  );

  // ARREADY is gated by reset so nothing looks accepted while the block is held
  assign in_idle_c  = ARESETN && (state == ST_IDLE);
  assign in_data_c  = (state == ST_DATA);
  assign S0_ARREADY = in_idle_c && pick_c[REQ_DISP];
  assign S1_ARREADY = in_idle_c && pick_c[REQ_AUX];

  assign S0_RVALID = in_data_c && GNT[REQ_DISP] && M_RVALID;
  assign S0_RLAST  = in_data_c && GNT[REQ_DISP] && M_RLAST;
  assign S1_RVALID = in_data_c && GNT[REQ_AUX] && M_RVALID;
  assign S1_RLAST  = in_data_c && GNT[REQ_AUX] && M_RLAST;
  assign S_RDATA   = M_RDATA;
  assign M_RREADY  = in_data_c && ((GNT[REQ_DISP] && S0_RREADY) || (GNT[REQ_AUX] && S1_RREADY));

  assign r_hs_c    = M_RVALID && M_RREADY;
  assign len_bad_c = M_RLAST ? (cnt != M_ARLEN) : (cnt == M_ARLEN);

  // Burst FSM with registered AR request, grant and sticky length error
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      GNT       <= '0;
      M_ARVALID <= 1'b0;
      M_ARADDR  <= '0;
      M_ARLEN   <= '0;
      last_gnt  <= 1'(REQ_AUX);
      cnt       <= '0;
      LEN_ERR   <= 1'b0;
    end else begin
      if (r_hs_c && len_bad_c) begin
        LEN_ERR <= 1'b1;
      end else if (ERR_CLR) begin
        LEN_ERR <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (|pick_c) begin
            M_ARADDR  <= pick_c[REQ_AUX] ? S1_ARADDR : S0_ARADDR;
            M_ARLEN   <= pick_c[REQ_AUX] ? S1_ARLEN : S0_ARLEN;
            GNT       <= pick_c;
            last_gnt  <= pick_c[REQ_AUX];
            cnt       <= '0;
            M_ARVALID <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_hs_c) begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
            if (M_RLAST) begin
              GNT   <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_rd_arbiter.sv
// Bench for disp_rd_arbiter: instance 0 uses display priority, instance 1 round-robin.
module tb_disp_rd_arbiter;
  import disp_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [AW-1:0] araddr  [2][2];
  logic [7:0]    arlen   [2][2];
  logic          arvalid [2][2];
  logic          arready [2][2];
  logic          rvalid  [2][2];
  logic          rlast   [2][2];
  logic          rready  [2][2];
  logic [DW-1:0] s_rdata   [2];
  logic [AW-1:0] m_araddr  [2];
  logic [7:0]    m_arlen   [2];
  logic          m_arvalid [2];
  logic          m_arready [2];
  logic [DW-1:0] m_rdata   [2];
  logic          m_rlast   [2];
  logic          m_rvalid  [2];
  logic          m_rready  [2];
  logic [1:0]    gnt       [2];
  logic          len_err   [2];
  logic          err_clr   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    disp_rd_arbiter #(
      .C_M_AXI_ADDR_WIDTH (AW),
      .C_M_AXI_DATA_WIDTH (DW),
      .DISP_PRIORITY      ((g == 0) ? 1 : 0)
    ) u_dut (
      .ACLK       (clk),
      .ARESETN    (rst_n),
      .S0_ARADDR  (araddr[g][0]),
      .S0_ARLEN   (arlen[g][0]),
      .S0_ARVALID (arvalid[g][0]),
      .S0_ARREADY (arready[g][0]),
      .S0_RVALID  (rvalid[g][0]),
      .S0_RLAST   (rlast[g][0]),
      .S0_RREADY  (rready[g][0]),
      .S1_ARADDR  (araddr[g][1]),
      .S1_ARLEN   (arlen[g][1]),
      .S1_ARVALID (arvalid[g][1]),
      .S1_ARREADY (arready[g][1]),
      .S1_RVALID  (rvalid[g][1]),
      .S1_RLAST   (rlast[g][1]),
      .S1_RREADY  (rready[g][1]),
      .S_RDATA    (s_rdata[g]),
      .M_ARADDR   (m_araddr[g]),
      .M_ARLEN    (m_arlen[g]),
      .M_ARVALID  (m_arvalid[g]),
      .M_ARREADY  (m_arready[g]),
      .M_RDATA    (m_rdata[g]),
      .M_RLAST    (m_rlast[g]),
      .M_RVALID   (m_rvalid[g]),
      .M_RREADY   (m_rready[g]),
      .GNT        (gnt[g]),
      .LEN_ERR    (len_err[g]),
      .ERR_CLR    (err_clr[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: who was granted last, and the sticky error the bursts so far imply
  int last_m [2];
  bit err_m  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance 0 always prefers display; otherwise alternate on contention
  function automatic int winner(input int d, input bit v0, input bit v1);
    if (d == 0 && v0) return 0;
    if (v0 && v1) return (last_m[d] == 0) ? 1 : 0;
    return v0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_m[d] = 1;
      err_m[d]  = 1'b0;
    end
  endtask

  task automatic chk_quiet(input int d, input string tag);
    chk({tag, "_gnt"}, 64'(gnt[d]), 64'd0);
    chk({tag, "_m_arvalid"}, 64'(m_arvalid[d]), 64'd0);
    chk({tag, "_m_rready"}, 64'(m_rready[d]), 64'd0);
    for (int r = 0; r < 2; r++) begin
      chk({tag, "_rvalid"}, 64'(rvalid[d][r]), 64'd0);
      chk({tag, "_rlast"}, 64'(rlast[d][r]), 64'd0);
    end
  endtask

  task automatic pulse_clr(input int d);
    @(negedge clk);
    err_clr[d] = 1'b1;
    @(negedge clk);
    err_clr[d] = 1'b0;
    err_m[d]   = 1'b0;
    #1;
    chk("err_clr", 64'(len_err[d]), 64'd0);
  endtask

  // One burst from requester 'who'; mode 0 = steady, 1 = RREADY toggling, 2 = random handshakes.
  // abort_beat >= 0 pulls reset while that beat is on the bus.
  task automatic do_burst(input int d, input int who, input logic [AW-1:0] addr,
                          input logic [7:0] len, input int nbeats, input int dly,
                          input int mode, input bit clr_last, input int abort_beat);
    int oth, beat, cyc;
    bit rv, rr;
    logic [DW-1:0] dat;
    oth = 1 - who;
    @(negedge clk);
    araddr[d][who]  = addr;
    arlen[d][who]   = len;
    arvalid[d][who] = 1'b1;
    #1;
    chk("arready_win", 64'(arready[d][who]), 64'd1);
    chk("arready_lose", 64'(arready[d][oth]), 64'd0);
    chk("gnt_idle", 64'(gnt[d]), 64'd0);
    last_m[d] = winner(d, who == 0, who == 1);
    @(negedge clk);
    arvalid[d][who] = 1'b0;
    araddr[d][who]  = ~addr;
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) @(negedge clk);
      m_arready[d] = (i == dly);
      #1;
      chk("m_arvalid", 64'(m_arvalid[d]), 64'd1);
      chk("m_araddr", 64'(m_araddr[d]), 64'(addr));
      chk("m_arlen", 64'(m_arlen[d]), 64'(len));
      chk("gnt_addr", 64'(gnt[d]), 64'd1 << who);
    end
    @(negedge clk);
    m_arready[d] = 1'b0;
    #1;
    chk("m_arvalid_once", 64'(m_arvalid[d]), 64'd0);
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 400) begin
      @(negedge clk);
      if (beat == abort_beat) begin
        rst_n = 1'b0;
        #1;
        chk_quiet(d, "rst");
        chk("rst_arready", 64'(arready[d][0]), 64'd0);
        chk("rst_len_err", 64'(len_err[d]), 64'd0);
        chk("rst_m_araddr", 64'(m_araddr[d]), 64'd0);
        m_rvalid[d] = 1'b0;
        m_rlast[d]  = 1'b0;
        rready[d][0] = 1'b0;
        rready[d][1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        return;
      end
      case (mode)
        1:       begin rv = 1'b1; rr = cyc[0]; end
        2:       begin rv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 2) != 0); end
        default: begin rv = 1'b1; rr = 1'b1; end
      endcase
      dat = $urandom;
      m_rvalid[d]  = rv;
      m_rdata[d]   = dat;
      m_rlast[d]   = (beat == nbeats - 1);
      rready[d][who] = rr;
      rready[d][oth] = 1'($urandom_range(0, 1));
      err_clr[d]   = clr_last && (beat == nbeats - 1);
      #1;
      chk("m_rready", 64'(m_rready[d]), 64'(rr));
      chk("own_rvalid", 64'(rvalid[d][who]), 64'(rv));
      chk("own_rlast", 64'(rlast[d][who]), 64'(beat == nbeats - 1));
      chk("oth_rvalid", 64'(rvalid[d][oth]), 64'd0);
      chk("oth_rlast", 64'(rlast[d][oth]), 64'd0);
      chk("s_rdata", 64'(s_rdata[d]), 64'(dat));
      chk("gnt_data", 64'(gnt[d]), 64'd1 << who);
      if (rv && rr) beat++;
      cyc++;
    end
    chk("beat_budget", 64'(cyc < 400), 64'd1);
    err_m[d] = err_m[d] | (nbeats != int'(len) + 1);
    @(negedge clk);
    m_rvalid[d]  = 1'b0;
    m_rlast[d]   = 1'b0;
    err_clr[d]   = 1'b0;
    rready[d][0] = 1'b0;
    rready[d][1] = 1'b0;
    #1;
    chk("gnt_done", 64'(gnt[d]), 64'd0);
    chk("m_rready_done", 64'(m_rready[d]), 64'd0);
    chk("len_err", 64'(len_err[d]), 64'(err_m[d]));
  endtask

  // Both requesters held valid; single-beat bursts, grant order from the model
  task automatic contend(input int d, input int nb);
    int w;
    logic [AW-1:0] addrs [2];
    addrs[0] = 32'h0000_A000;
    addrs[1] = 32'h0000_B000;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      araddr[d][r]  = addrs[r];
      arlen[d][r]   = 8'd0;
      arvalid[d][r] = 1'b1;
      rready[d][r]  = 1'b1;
    end
    for (int b = 0; b < nb; b++) begin
      w = winner(d, 1'b1, 1'b1);
      #1;
      chk("c_arready_win", 64'(arready[d][w]), 64'd1);
      chk("c_arready_lose", 64'(arready[d][1-w]), 64'd0);
      last_m[d] = w;
      @(negedge clk);
      #1;
      chk("c_gnt", 64'(gnt[d]), 64'd1 << w);
      chk("c_m_araddr", 64'(m_araddr[d]), 64'(addrs[w]));
      m_arready[d] = 1'b1;
      @(negedge clk);
      m_arready[d] = 1'b0;
      m_rvalid[d]  = 1'b1;
      m_rlast[d]   = 1'b1;
      m_rdata[d]   = $urandom;
      #1;
      chk("c_rvalid_own", 64'(rvalid[d][w]), 64'd1);
      chk("c_rvalid_oth", 64'(rvalid[d][1-w]), 64'd0);
      chk("c_gnt_data", 64'(gnt[d]), 64'd1 << w);
      @(negedge clk);
      m_rvalid[d] = 1'b0;
      m_rlast[d]  = 1'b0;
    end
    for (int r = 0; r < 2; r++) begin
      arvalid[d][r] = 1'b0;
      rready[d][r]  = 1'b0;
    end
    #1;
    chk("c_gnt_end", 64'(gnt[d]), 64'd0);
    chk("c_len_err", 64'(len_err[d]), 64'(err_m[d]));
  endtask

  initial begin
    int d, who, nb, dly;
    logic [7:0] len;
    for (int i = 0; i < 2; i++) begin
      m_arready[i] = 1'b0;
      m_rvalid[i]  = 1'b0;
      m_rlast[i]   = 1'b0;
      m_rdata[i]   = '0;
      err_clr[i]   = 1'b0;
      for (int r = 0; r < 2; r++) begin
        araddr[i][r]  = '0;
        arlen[i][r]   = '0;
        arvalid[i][r] = 1'b0;
        rready[i][r]  = 1'b0;
      end
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_quiet(i, "init");
      chk("init_len_err", 64'(len_err[i]), 64'd0);
      chk("init_m_araddr", 64'(m_araddr[i]), 64'd0);
      chk("init_m_arlen", 64'(m_arlen[i]), 64'd0);
      chk("init_arready", 64'(arready[i][0]), 64'd0);
    end

    // round-robin grant order from reset, then strict priority
    contend(1, 3);
    contend(0, 4);

    // 16-beat display burst with RREADY toggling, then a stalled AR handshake
    do_burst(0, 0, 32'h1000_0000, ARLEN_16, 16, 0, 1, 1'b0, -1);
    do_burst(0, 0, 32'h2000_0040, 8'd3, 4, 5, 0, 1'b0, -1);

    // short burst, clear, simultaneous set+clear, overrun
    do_burst(0, 1, 32'h3000_0000, ARLEN_16, 8, 0, 0, 1'b0, -1);
    pulse_clr(0);
    do_burst(1, 0, 32'h3100_0000, 8'd3, 2, 1, 0, 1'b1, -1);
    pulse_clr(1);
    do_burst(1, 1, 32'h3200_0000, 8'd1, 4, 0, 0, 1'b0, -1);
    pulse_clr(1);
    do_burst(0, 0, 32'h3300_0000, 8'd0, 1, 0, 0, 1'b0, -1);

    // reset during beat 5, then a fresh requester-1 burst
    do_burst(1, 0, 32'h4000_0000, ARLEN_16, 16, 0, 0, 1'b0, 4);
    do_burst(1, 1, 32'h4100_0000, 8'd7, 8, 1, 0, 1'b0, -1);
    contend(1, 2);

    for (int k = 0; k < 24; k++) begin
      d   = int'($urandom_range(0, 1));
      who = int'($urandom_range(0, 1));
      len = 8'($urandom_range(0, 6));
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : int'(len) + 1;
      dly = int'($urandom_range(0, 3));
      if (err_m[d] && $urandom_range(0, 1) == 1) pulse_clr(d);
      do_burst(d, who, $urandom, len, nb, dly, 2, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
